demux: RTL and testbench
========================

Name: demux

Overview:
- Stream demultiplexer; the inverse of the N-to-1 operand mux.
- Takes one W-bit input beat plus a destination index and delivers it to exactly one of N output channels.
- Uses per-channel valid/ready handshakes.
- Sits between a single producer (e.g. a compute result path) and N consumer lanes, with optional input and output pipeline registers.

Parameters:
N, 2, number of output channels (2..16)
W, 32, data width
IREG, 1, 1 = registered input stage; 0 = combinational pass-through
OREG, 1, 1 = per-channel output registers; 0 = combinational outputs

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous reset, active low
ce_i  input  1  clock enable; no state changes and no transfers while low
op_i  input  W  input data beat
sel_i  input  N  binary destination index (N bits wide for tool reasons; only values 0..N-1 are valid)
valid_i  input  1  input beat valid
ready_o  output  1  input beat accepted when valid_i && ready_o && ce_i
res_o  output  [W-1:0] x N (unpacked array)  per-channel data
valid_o  output  N  per-channel valid
ready_i  input  N  per-channel ready; transfer on channel k when valid_o[k] && ready_i[k] && ce_i
err_o  output  1  one-cycle pulse on drop of a beat with invalid sel

Behaviour:
Reset (rst_ni low, asynchronous):
- All stage valids clear.
- valid_o = 0, res_o = 0, err_o = 0, counters = 0.
- Deasserting reset mid-stream discards any held beats; there is no partial delivery.

Stage A (input, exists when IREG=1):
- One-entry register {data, sel, full}.
- ready_o = ce_i && (!A.full || A.leaving).
- A.leaving is true when:
  - A's beat moves to stage B / output this cycle, or
  - A's beat is dropped for invalid sel.
- Simultaneous accept and leave is allowed, giving full throughput.

Stage B (per channel k, exists when OREG=1):
- One-entry register per channel.
- Loads from A (or from the input directly when IREG=0) when the beat's sel == k and (!valid_o[k] || ready_i[k]).
- A refill and a drain on the same channel in the same cycle is allowed.

Bypass modes:
- IREG=0: the input feeds stage B directly, so ready_o depends combinationally on the selected channel's slot state and ready_i[sel_i].
- IREG=0 and OREG=0: fully combinational.
  - valid_o[k] = valid_i && ce_i && sel_i == k.
  - res_o[k] = op_i; unselected channels hold 0.
  - ready_o = ready_i[sel_i].

Latency (accepted beat to valid_o on an unstalled path) = IREG + OREG cycles.

Ordering:
- Strictly in-order; no bypass.
- A beat stalled in A (destination channel full and not draining) blocks all later beats, including those for idle channels (head-of-line blocking is intended).

Invalid sel (sel >= N):
- The beat is accepted normally, then discarded at the stage where routing occurs; it never asserts any valid_o.
- err_o pulses high for exactly one cycle, registered, in the cycle after the discard.
- Back-to-back invalid beats give consecutive err_o pulses.

Clock enable (ce_i low):
- All registers hold, ready_o = 0, valid_o and res_o hold their values.
- Downstream ready_i has no effect.

Data stability: res_o[k] changes only when channel k loads; it is held while valid_o[k] && !ready_i[k].

Optional Feature:
DEMUX_DROP_CNT_EN
- Defined:
  - Adds output port drop_cnt_o [15:0]: count of invalid-sel drops, saturating at 16'hFFFF.
  - Reset to 0; increments in the same cycle err_o asserts.
- Undefined:
  - Port and counter are absent.
  - err_o behaviour is unchanged.

Test Plan:
- N=4, IREG=OREG=1, all ready_i=1, beats 0xA0..0xA3 with sel 0,1,2,3 on consecutive cycles -> valid_o[k] high exactly 2 cycles after each accept, res_o[k]=0xA0+k, ready_o never deasserts.
- ready_i[1]=0; send sel=1 0x11, sel=1 0x22, sel=0 0x33 -> 0x11 held on res_o[1]; 0x22 stalls in A; ready_o drops; 0x33 not delivered until ready_i[1]=1. Then order is 0x11, 0x22 on ch1, then 0x33 on ch0.
- sel=7 with N=4, data 0xDEAD -> no valid_o asserted, err_o one-cycle pulse; with DEMUX_DROP_CNT_EN, drop_cnt_o goes 0->1. Force 65536 drops -> drop_cnt_o stays 0xFFFF.
- Stream on ch2 with ce_i pulled low for 3 cycles mid-transfer -> all outputs frozen, no beat lost or duplicated, and delivery resumes when ce_i returns high.
- Assert rst_ni low asynchronously (between clock edges) with beats in A and B -> valid_o, res_o, err_o go 0 immediately; after release, the first new beat is delivered with normal latency.
- IREG=OREG=0, sel_i=2, valid_i=1, ready_i=4'b0100 -> same-cycle valid_o=4'b0100, res_o[2]=op_i, ready_o=1; with ready_i[2]=0 -> ready_o=0.

Source files
------------

// File: rtl/demux.sv
// Stream demultiplexer: one W-bit beat plus destination index delivered to one of N lanes,
// with optional input (IREG) and per-lane output (OREG) registers. Define DEMUX_DROP_CNT_EN for drop_cnt_o.
module demux #(
    parameter int N    = 2,
    parameter int W    = 32,
    parameter int IREG = 1,
    parameter int OREG = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         ce_i,
    input  logic [W-1:0] op_i,
    input  logic [N-1:0] sel_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic [W-1:0] res_o [N],
    output logic [N-1:0] valid_o,
    input  logic [N-1:0] ready_i,
    output logic         err_o
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]  drop_cnt_o
`endif
);

    // Head beat: the oldest beat waiting to be routed (stage A, or the input itself).
    logic         h_valid;
    logic [W-1:0] h_data;
    logic [N-1:0] h_sel;
    logic [N-1:0] h_hit;
    logic         h_inv;
    logic         h_leave;
    logic [N-1:0] slot_free;
    logic         err_d;
    logic         err_q;

    always_comb begin
        h_hit = '0;
        for (int k = 0; k < N; k++) begin
            h_hit[k] = (h_sel == k[N-1:0]);
        end
    end

    // An out-of-range index matches no lane; such a beat always leaves and is dropped.
    assign h_inv   = ~|h_hit;
    assign h_leave = ce_i && h_valid && (h_inv || |(h_hit & slot_free));

    generate
        if (IREG != 0) begin : g_ireg
            logic         a_full_q;
            logic         a_full_d;
            logic [W-1:0] a_data_q;
            logic [W-1:0] a_data_d;
            logic [N-1:0] a_sel_q;
            logic [N-1:0] a_sel_d;

            assign ready_o = ce_i && (!a_full_q || h_leave);
            assign h_valid = a_full_q;
            assign h_data  = a_data_q;
            assign h_sel   = a_sel_q;

            always_comb begin
                a_full_d = a_full_q;
                a_data_d = a_data_q;
                a_sel_d  = a_sel_q;
                if (h_leave) begin
                    a_full_d = 1'b0;
                end
                if (valid_i && ready_o) begin
                    a_full_d = 1'b1;
                    a_data_d = op_i;
                    a_sel_d  = sel_i;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a_full_q <= 1'b0;
                    a_data_q <= '0;
                    a_sel_q  <= '0;
                end else begin
                    a_full_q <= a_full_d;
                    a_data_q <= a_data_d;
                    a_sel_q  <= a_sel_d;
                end
            end
        end else begin : g_no_ireg
            assign h_valid = valid_i;
            assign h_data  = op_i;
            assign h_sel   = sel_i;
            assign ready_o = ce_i && (h_inv || |(h_hit & slot_free));
        end
    endgenerate

    generate
        if (OREG != 0) begin : g_oreg
            logic [N-1:0] out_valid_q;
            logic [N-1:0] out_valid_d;
            logic [N-1:0] load;
            logic [W-1:0] out_data_q [N];
            logic [W-1:0] out_data_d [N];

            assign load      = h_leave ? h_hit : '0;
            assign slot_free = ~out_valid_q | ready_i;

            // Drain and refill in the same cycle: the load wins, keeping the slot full.
            always_comb begin
                out_valid_d = out_valid_q;
                out_data_d  = out_data_q;
                for (int k = 0; k < N; k++) begin
                    if (ce_i && ready_i[k]) begin
                        out_valid_d[k] = 1'b0;
                    end
                    if (load[k]) begin
                        out_valid_d[k] = 1'b1;
                        out_data_d[k]  = h_data;
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    out_valid_q <= '0;
                    for (int k = 0; k < N; k++) begin
                        out_data_q[k] <= '0;
                    end
                end else begin
                    out_valid_q <= out_valid_d;
                    for (int k = 0; k < N; k++) begin
                        out_data_q[k] <= out_data_d[k];
                    end
                end
            end

            assign valid_o = out_valid_q;
            always_comb begin
                for (int k = 0; k < N; k++) begin
                    res_o[k] = out_data_q[k];
                end
            end
        end else begin : g_no_oreg
            logic [N-1:0] route_v;

            assign slot_free = ready_i;

            // A registered head already holds under ce_i low; a raw input must be gated.
            always_comb begin
                route_v = '0;
                for (int k = 0; k < N; k++) begin
                    route_v[k] = h_valid && h_hit[k] && ((IREG != 0) || ce_i);
                    res_o[k]   = route_v[k] ? h_data : '0;
                end
            end
            assign valid_o = route_v;
        end
    endgenerate

    // err_q follows err_d even under ce_i low so the pulse never stretches.
    assign err_d = h_leave && h_inv;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef DEMUX_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    logic [15:0] drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (err_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux.sv
// Directed bench for demux: registered N=4 instance plus a fully combinational N=4 instance.
module tb_demux;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [31:0] op;
    logic [3:0]  sel;
    logic        vin;
    logic        rdy_o;
    logic [31:0] res [4];
    logic [3:0]  vout;
    logic [3:0]  rdy_i;
    logic        err;
`ifdef DEMUX_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    logic        c_ce;
    logic [31:0] c_op;
    logic [3:0]  c_sel;
    logic        c_vin;
    logic        c_rdy_o;
    logic [31:0] c_res [4];
    logic [3:0]  c_vout;
    logic [3:0]  c_rdy_i;
    logic        c_err;

    int checks = 0;
    int errors = 0;

    demux #(.N(4), .W(32), .IREG(1), .OREG(1)) u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .ce_i      (ce),
        .op_i      (op),
        .sel_i     (sel),
        .valid_i   (vin),
        .ready_o   (rdy_o),
        .res_o     (res),
        .valid_o   (vout),
        .ready_i   (rdy_i),
        .err_o     (err)
`ifdef DEMUX_DROP_CNT_EN
        ,
        .drop_cnt_o(drop_cnt)
`endif
    );

    demux #(.N(4), .W(32), .IREG(0), .OREG(0)) u_comb (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .ce_i      (c_ce),
        .op_i      (c_op),
        .sel_i     (c_sel),
        .valid_i   (c_vin),
        .ready_o   (c_rdy_o),
        .res_o     (c_res),
        .valid_o   (c_vout),
        .ready_i   (c_rdy_i),
        .err_o     (c_err)
`ifdef DEMUX_DROP_CNT_EN
        ,
        .drop_cnt_o()
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ce    = 1'b1;
        op    = '0;
        sel   = '0;
        vin   = 1'b0;
        rdy_i = 4'hF;
        c_ce  = 1'b1;
        c_op  = '0;
        c_sel = '0;
        c_vin = 1'b0;
        c_rdy_i = '0;

        // Reset state
        tick();
        tick();
        chk("rst_valid_o", 32'(vout), 32'h0);
        for (int k = 0; k < 4; k++) chk($sformatf("rst_res_o%0d", k), res[k], 32'h0);
        chk("rst_err_o", 32'(err), 32'h0);
        chk("rst_ready_o", 32'(rdy_o), 32'h1);
`ifdef DEMUX_DROP_CNT_EN
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif
        rst_n = 1'b1;

        // Full-throughput sweep over all four lanes, latency 2
        vin = 1'b1; sel = 4'd0; op = 32'hA0;
        #1 chk("sweep_ready0", 32'(rdy_o), 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("sweep_valid%0d", i), 32'(vout),
                (i >= 1 && i <= 4) ? (32'h1 << (i - 1)) : 32'h0);
            if (i >= 1 && i <= 4) chk($sformatf("sweep_res%0d", i), res[i-1], 32'hA0 + 32'(i - 1));
            if (i < 3) begin
                sel = 4'(i + 1); op = 32'hA1 + 32'(i);
                #1 chk($sformatf("sweep_ready%0d", i + 1), 32'(rdy_o), 32'h1);
            end else begin
                vin = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) chk($sformatf("sweep_hold%0d", k), res[k], 32'hA0 + 32'(k));

        // Head-of-line blocking behind a stalled lane 1
        rdy_i = 4'b1101;
        vin = 1'b1; sel = 4'd1; op = 32'h11;
        tick();
        sel = 4'd1; op = 32'h22;
        #1 chk("hol_ready_a", 32'(rdy_o), 32'h1);
        tick();
        sel = 4'd0; op = 32'h33;
        #1 chk("hol_ready_stall", 32'(rdy_o), 32'h0);
        chk("hol_valid_a", 32'(vout), 32'h2);
        chk("hol_res1_a", res[1], 32'h11);
        tick();
        chk("hol_valid_b", 32'(vout), 32'h2);
        chk("hol_res1_b", res[1], 32'h11);
        chk("hol_ready_b", 32'(rdy_o), 32'h0);
        tick();
        chk("hol_valid_c", 32'(vout), 32'h2);
        rdy_i = 4'hF;
        #1 chk("hol_ready_free", 32'(rdy_o), 32'h1);
        tick();
        vin = 1'b0;
        chk("hol_valid_d", 32'(vout), 32'h2);
        chk("hol_res1_d", res[1], 32'h22);
        tick();
        chk("hol_valid_e", 32'(vout), 32'h1);
        chk("hol_res0_e", res[0], 32'h33);
        tick();
        chk("hol_valid_f", 32'(vout), 32'h0);

        // Invalid destination: dropped, one err pulse, back-to-back pulses
        vin = 1'b1; sel = 4'd7; op = 32'hDEAD;
        tick();
        vin = 1'b0;
        chk("inv_err_a", 32'(err), 32'h0);
        tick();
        chk("inv_err_b", 32'(err), 32'h1);
        chk("inv_valid_b", 32'(vout), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
        chk("inv_cnt_b", 32'(drop_cnt), 32'h1);
`endif
        tick();
        chk("inv_err_c", 32'(err), 32'h0);
        vin = 1'b1; sel = 4'd4; op = 32'h44;
        tick();
        sel = 4'd9; op = 32'h99;
        tick();
        vin = 1'b0;
        chk("b2b_err_a", 32'(err), 32'h1);
        tick();
        chk("b2b_err_b", 32'(err), 32'h1);
`ifdef DEMUX_DROP_CNT_EN
        chk("b2b_cnt", 32'(drop_cnt), 32'h3);
`endif
        tick();
        chk("b2b_err_c", 32'(err), 32'h0);
        chk("b2b_valid", 32'(vout), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
        vin = 1'b1; sel = 4'd15; op = 32'hF;
        for (int i = 0; i < 65535; i++) tick();
        vin = 1'b0;
        tick();
        tick();
        chk("sat_cnt", 32'(drop_cnt), 32'hFFFF);
`endif

        // Clock enable freeze on lane 2
        vin = 1'b1; sel = 4'd2; op = 32'h21;
        tick();
        op = 32'h22;
        tick();
        op = 32'h23;
        ce = 1'b0;
        #1 chk("ce_ready_low", 32'(rdy_o), 32'h0);
        chk("ce_valid_0", 32'(vout), 32'h4);
        chk("ce_res2_0", res[2], 32'h21);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ce_valid_h%0d", i), 32'(vout), 32'h4);
            chk($sformatf("ce_res2_h%0d", i), res[2], 32'h21);
        end
        ce = 1'b1;
        tick();
        vin = 1'b0;
        chk("ce_res2_r1", res[2], 32'h22);
        tick();
        chk("ce_res2_r2", res[2], 32'h23);
        chk("ce_valid_r2", 32'(vout), 32'h4);
        tick();
        chk("ce_valid_r3", 32'(vout), 32'h0);

        // Asynchronous reset with beats in A and B and err high
        rdy_i = 4'b1110;
        vin = 1'b1; sel = 4'd0; op = 32'h51;
        tick();
        sel = 4'd5; op = 32'h55;
        tick();
        sel = 4'd1; op = 32'h52;
        tick();
        vin = 1'b0;
        chk("ar_valid_pre", 32'(vout), 32'h1);
        chk("ar_res0_pre", res[0], 32'h51);
        chk("ar_err_pre", 32'(err), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("ar_valid", 32'(vout), 32'h0);
        chk("ar_res0", res[0], 32'h0);
        chk("ar_err", 32'(err), 32'h0);
        tick();
        rst_n = 1'b1;
        rdy_i = 4'hF;
        vin = 1'b1; sel = 4'd3; op = 32'h5A;
        tick();
        vin = 1'b0;
        chk("ar_post_valid_a", 32'(vout), 32'h0);
        tick();
        chk("ar_post_valid_b", 32'(vout), 32'h8);
        chk("ar_post_res3", res[3], 32'h5A);

        // Fully combinational instance
        c_vin = 1'b1; c_sel = 4'd2; c_op = 32'hC0FFEE; c_rdy_i = 4'b0100;
        #1 chk("comb_valid", 32'(c_vout), 32'h4);
        chk("comb_res2", c_res[2], 32'hC0FFEE);
        chk("comb_res0", c_res[0], 32'h0);
        chk("comb_ready", 32'(c_rdy_o), 32'h1);
        c_rdy_i = 4'b1011;
        #1 chk("comb_ready_low", 32'(c_rdy_o), 32'h0);
        chk("comb_valid_nr", 32'(c_vout), 32'h4);
        c_ce = 1'b0;
        #1 chk("comb_ce_valid", 32'(c_vout), 32'h0);
        chk("comb_ce_ready", 32'(c_rdy_o), 32'h0);
        tick();
        c_ce = 1'b1; c_sel = 4'd6;
        #1 chk("comb_inv_ready", 32'(c_rdy_o), 32'h1);
        chk("comb_inv_valid", 32'(c_vout), 32'h0);
        tick();
        c_vin = 1'b0;
        chk("comb_err_a", 32'(c_err), 32'h1);
        tick();
        chk("comb_err_b", 32'(c_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
